// File: rtl/bus_timing.sv
// Bus-slot timing generator: per-slot setup/enable/disable strobes, one-hot slot grant and CPU clock.
// Optional CPU-slot cancellation by bus masters is compiled in with BUS_TIMING_HOLD_EN.
module bus_timing #(
    parameter int SLOT_CYCLES   = 8,
    parameter int NUM_SLOTS     = 8,
    parameter int SETUP_PHASE   = 0,
    parameter int ENABLE_PHASE  = 2,
    parameter int DISABLE_PHASE = 6
) (
    input  logic                         clk_sys_i,
    input  logic                         reset_i,
    input  logic [1:0]                   speed_i,
    input  logic                         cpu_hold_i,
    output logic                         clk_setup_o,
    output logic                         clk_enable_o,
    output logic                         clk_disable_o,
    output logic [NUM_SLOTS-1:0]         slot_o,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_idx_o,
    output logic                         frame_o,
    output logic                         cpu_slot_o,
    output logic [1:0]                   speed_active_o,
    output logic                         cpu_clk_o
);

    localparam int PW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(NUM_SLOTS);

    if (SLOT_CYCLES < 4 || (SLOT_CYCLES & (SLOT_CYCLES - 1)) != 0) begin : g_chk_slot_cycles
        $error("bus_timing: SLOT_CYCLES must be a power of two >= 4");
    end
    if (NUM_SLOTS < 8 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_chk_num_slots
        $error("bus_timing: NUM_SLOTS must be a power of two >= 8");
    end
    if (!(SETUP_PHASE >= 0 && SETUP_PHASE < ENABLE_PHASE &&
          ENABLE_PHASE < DISABLE_PHASE && DISABLE_PHASE < SLOT_CYCLES)) begin : g_chk_phases
        $error("bus_timing: require SETUP_PHASE < ENABLE_PHASE < DISABLE_PHASE < SLOT_CYCLES");
    end

    logic [PW-1:0]        phase_q, phase_d;
    logic                 setup_q, setup_d;
    logic                 enable_q, enable_d;
    logic                 disable_q, disable_d;
    logic [NUM_SLOTS-1:0] slot_q, slot_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 frame_q, frame_d;
    logic                 cpu_slot_q, cpu_slot_d;
    logic [1:0]           speed_q, speed_d;
    logic                 cpu_clk_q, cpu_clk_d;

    logic                 advance;
    logic                 at_enable;
    logic                 at_disable;
    logic [IW-1:0]        idx_next;
    logic                 wrap_to_zero;
    logic [1:0]           speed_eff;
    logic [IW:0]          stride;
    logic [IW-1:0]        stride_mask;
    logic                 is_cpu;
    logic                 hold_cancel;

`ifdef BUS_TIMING_HOLD_EN
    assign hold_cancel = cpu_hold_i;
`else
    logic unused_hold;
    assign unused_hold = cpu_hold_i;
    assign hold_cancel = 1'b0;
`endif

    // CPU-slot decision is made for the incoming slot; a new frame uses the freshly sampled speed.
    always_comb begin
        advance      = (phase_q == PW'(SETUP_PHASE));
        at_enable    = (phase_q == PW'(ENABLE_PHASE));
        at_disable   = (phase_q == PW'(DISABLE_PHASE));
        idx_next     = idx_q + IW'(1);
        wrap_to_zero = (idx_next == '0);
        speed_eff    = wrap_to_zero ? speed_i : speed_q;
        stride       = (IW + 1)'(NUM_SLOTS) >> speed_eff;
        if (stride == '0) begin
            stride = (IW + 1)'(1);
        end
        stride_mask  = IW'(stride - (IW + 1)'(1));
        is_cpu       = ((idx_next & stride_mask) == '0);
    end

    always_comb begin
        phase_d    = phase_q + PW'(1);
        setup_d    = advance;
        enable_d   = at_enable;
        disable_d  = at_disable;
        slot_d     = slot_q;
        idx_d      = idx_q;
        frame_d    = 1'b0;
        speed_d    = speed_q;
        cpu_slot_d = cpu_slot_q;
        cpu_clk_d  = cpu_clk_q;

        if (advance) begin
            slot_d     = {slot_q[NUM_SLOTS-2:0], slot_q[NUM_SLOTS-1]};
            idx_d      = idx_next;
            frame_d    = wrap_to_zero;
            cpu_slot_d = is_cpu & ~hold_cancel;
            if (wrap_to_zero) begin
                speed_d = speed_i;
            end
        end

        if (at_enable && cpu_slot_q) begin
            cpu_clk_d = 1'b1;
        end
        if (at_disable) begin
            cpu_clk_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q    <= '0;
            setup_q    <= 1'b0;
            enable_q   <= 1'b0;
            disable_q  <= 1'b0;
            slot_q     <= {1'b1, {(NUM_SLOTS - 1){1'b0}}};
            idx_q      <= IW'(NUM_SLOTS - 1);
            frame_q    <= 1'b0;
            cpu_slot_q <= 1'b0;
            speed_q    <= 2'd0;
            cpu_clk_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            setup_q    <= setup_d;
            enable_q   <= enable_d;
            disable_q  <= disable_d;
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            cpu_slot_q <= cpu_slot_d;
            speed_q    <= speed_d;
            cpu_clk_q  <= cpu_clk_d;
        end
    end

    assign clk_setup_o    = setup_q;
    assign clk_enable_o   = enable_q;
    assign clk_disable_o  = disable_q;
    assign slot_o         = slot_q;
    assign slot_idx_o     = idx_q;
    assign frame_o        = frame_q;
    assign cpu_slot_o     = cpu_slot_q;
    assign speed_active_o = speed_q;
    assign cpu_clk_o      = cpu_clk_q;

endmodule

// File: tb/tb_bus_timing.sv
// Directed bench for bus_timing: default-parameter instance plus a 16x16-slot instance.
module tb_bus_timing;

    logic        clk;
    logic        rst;
    logic [1:0]  speed;
    logic        hold;

    logic        a_setup, a_enable, a_disable, a_frame, a_cpu_slot, a_cpu_clk;
    logic [7:0]  a_slot;
    logic [2:0]  a_idx;
    logic [1:0]  a_speed;

    logic        b_setup, b_enable, b_disable, b_frame, b_cpu_slot, b_cpu_clk;
    logic [15:0] b_slot;
    logic [3:0]  b_idx;
    logic [1:0]  b_speed;

    int n_cmp = 0;
    int n_err = 0;
    int e     = 0;

    bus_timing dut_a (
        .clk_sys_i      (clk),
        .reset_i        (rst),
        .speed_i        (speed),
        .cpu_hold_i     (hold),
        .clk_setup_o    (a_setup),
        .clk_enable_o   (a_enable),
        .clk_disable_o  (a_disable),
        .slot_o         (a_slot),
        .slot_idx_o     (a_idx),
        .frame_o        (a_frame),
        .cpu_slot_o     (a_cpu_slot),
        .speed_active_o (a_speed),
        .cpu_clk_o      (a_cpu_clk)
    );

    bus_timing #(
        .SLOT_CYCLES   (16),
        .NUM_SLOTS     (16),
        .SETUP_PHASE   (1),
        .ENABLE_PHASE  (4),
        .DISABLE_PHASE (12)
    ) dut_b (
        .clk_sys_i      (clk),
        .reset_i        (rst),
        .speed_i        (speed),
        .cpu_hold_i     (hold),
        .clk_setup_o    (b_setup),
        .clk_enable_o   (b_enable),
        .clk_disable_o  (b_disable),
        .slot_o         (b_slot),
        .slot_idx_o     (b_idx),
        .frame_o        (b_frame),
        .cpu_slot_o     (b_cpu_slot),
        .speed_active_o (b_speed),
        .cpu_clk_o      (b_cpu_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        e = 0;
    endtask

    task automatic test_reset();
        speed = 2'd0;
        hold  = 1'b0;
        apply_reset();
        n_cmp++; if (a_slot !== 8'h80) begin n_err++; $display("FAIL rst_slot got %h expected 80", a_slot); end
        n_cmp++; if (a_idx !== 3'd7) begin n_err++; $display("FAIL rst_idx got %0d expected 7", a_idx); end
        n_cmp++; if ({a_setup, a_enable, a_disable, a_frame} !== 4'b0) begin n_err++; $display("FAIL rst_strobes got %b expected 0000", {a_setup, a_enable, a_disable, a_frame}); end
        n_cmp++; if ({a_cpu_slot, a_cpu_clk} !== 2'b0) begin n_err++; $display("FAIL rst_cpu got %b expected 00", {a_cpu_slot, a_cpu_clk}); end
        n_cmp++; if (a_speed !== 2'd0) begin n_err++; $display("FAIL rst_speed got %0d expected 0", a_speed); end
        n_cmp++; if (b_slot !== 16'h8000) begin n_err++; $display("FAIL rst_b_slot got %h expected 8000", b_slot); end
        n_cmp++; if (b_idx !== 4'd15) begin n_err++; $display("FAIL rst_b_idx got %0d expected 15", b_idx); end
    endtask

    task automatic test_speed0();
        int         sidx;
        logic [7:0] exp_slot;
        logic       exp_clk;
        speed = 2'd0;
        hold  = 1'b0;
        apply_reset();
        for (int k = 0; k < 128; k++) begin
            step();
            sidx     = ((e - 1) / 8) % 8;
            exp_slot = 8'h01 << sidx;
            exp_clk  = (e % 8 >= 3) && (e % 8 <= 6) && (sidx == 0);
            n_cmp++; if (a_setup !== (e % 8 == 1)) begin n_err++; $display("FAIL s0_setup edge %0d got %b", e, a_setup); end
            n_cmp++; if (a_enable !== (e % 8 == 3)) begin n_err++; $display("FAIL s0_enable edge %0d got %b", e, a_enable); end
            n_cmp++; if (a_disable !== (e % 8 == 7)) begin n_err++; $display("FAIL s0_disable edge %0d got %b", e, a_disable); end
            n_cmp++; if (a_frame !== (e == 1 || e == 65)) begin n_err++; $display("FAIL s0_frame edge %0d got %b", e, a_frame); end
            n_cmp++; if (a_slot !== exp_slot) begin n_err++; $display("FAIL s0_slot edge %0d got %h expected %h", e, a_slot, exp_slot); end
            n_cmp++; if (a_idx !== 3'(sidx)) begin n_err++; $display("FAIL s0_idx edge %0d got %0d expected %0d", e, a_idx, sidx); end
            n_cmp++; if (a_cpu_slot !== (sidx == 0)) begin n_err++; $display("FAIL s0_cpu_slot edge %0d got %b", e, a_cpu_slot); end
            n_cmp++; if (a_cpu_clk !== exp_clk) begin n_err++; $display("FAIL s0_cpu_clk edge %0d got %b expected %b", e, a_cpu_clk, exp_clk); end
        end
    endtask

    task automatic test_speed3();
        speed = 2'd3;
        hold  = 1'b0;
        apply_reset();
        for (int k = 0; k < 64; k++) begin
            step();
            n_cmp++; if (a_cpu_clk !== ((e % 8 >= 3) && (e % 8 <= 6))) begin n_err++; $display("FAIL s3_cpu_clk edge %0d got %b", e, a_cpu_clk); end
            n_cmp++; if (a_cpu_slot !== 1'b1) begin n_err++; $display("FAIL s3_cpu_slot edge %0d got %b expected 1", e, a_cpu_slot); end
            n_cmp++; if (a_speed !== 2'd3) begin n_err++; $display("FAIL s3_speed edge %0d got %0d expected 3", e, a_speed); end
        end
    endtask

    task automatic test_speed_switch();
        int   sidx;
        logic exp_clk;
        speed = 2'd0;
        hold  = 1'b0;
        apply_reset();
        for (int k = 0; k < 128; k++) begin
            step();
            sidx    = ((e - 1) / 8) % 8;
            exp_clk = (e % 8 >= 3) && (e % 8 <= 6) && ((e < 65) ? (sidx == 0) : (sidx % 2 == 0));
            n_cmp++; if (a_cpu_clk !== exp_clk) begin n_err++; $display("FAIL sw_cpu_clk edge %0d got %b expected %b", e, a_cpu_clk, exp_clk); end
            n_cmp++; if (a_speed !== ((e >= 65) ? 2'd2 : 2'd0)) begin n_err++; $display("FAIL sw_speed edge %0d got %0d", e, a_speed); end
            if (e == 20) speed = 2'd2;
        end
    endtask

    task automatic test_hold();
        logic hold_en;
        logic cancelled;
`ifdef BUS_TIMING_HOLD_EN
        hold_en = 1'b1;
`else
        hold_en = 1'b0;
`endif
        speed = 2'd3;
        hold  = 1'b0;
        apply_reset();
        for (int k = 0; k < 24; k++) begin
            step();
            cancelled = hold_en && (e >= 9) && (e <= 16);
            n_cmp++; if (a_cpu_clk !== ((e % 8 >= 3) && (e % 8 <= 6) && !cancelled)) begin n_err++; $display("FAIL hold_cpu_clk edge %0d got %b", e, a_cpu_clk); end
            n_cmp++; if (a_cpu_slot !== !cancelled) begin n_err++; $display("FAIL hold_cpu_slot edge %0d got %b expected %b", e, a_cpu_slot, !cancelled); end
            if (e == 8) hold = 1'b1;
            if (e == 9) hold = 1'b0;
        end
    endtask

    task automatic test_reset_mid_pulse();
        speed = 2'd3;
        hold  = 1'b0;
        apply_reset();
        repeat (4) step();
        n_cmp++; if (a_cpu_clk !== 1'b1) begin n_err++; $display("FAIL mid_pre_cpu_clk got %b expected 1", a_cpu_clk); end
        rst = 1'b1;
        #1;
        n_cmp++; if (a_cpu_clk !== 1'b0) begin n_err++; $display("FAIL mid_cpu_clk got %b expected 0", a_cpu_clk); end
        n_cmp++; if (a_slot !== 8'h80) begin n_err++; $display("FAIL mid_slot got %h expected 80", a_slot); end
        n_cmp++; if (a_idx !== 3'd7) begin n_err++; $display("FAIL mid_idx got %0d expected 7", a_idx); end
        n_cmp++; if ({a_setup, a_enable, a_disable, a_frame, a_cpu_slot} !== 5'b0) begin n_err++; $display("FAIL mid_strobes got %b expected 00000", {a_setup, a_enable, a_disable, a_frame, a_cpu_slot}); end
        n_cmp++; if (a_speed !== 2'd0) begin n_err++; $display("FAIL mid_speed got %0d expected 0", a_speed); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        e = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            n_cmp++; if (a_setup !== (e == 1)) begin n_err++; $display("FAIL mid_rel_setup edge %0d got %b", e, a_setup); end
            n_cmp++; if (a_enable !== (e == 3)) begin n_err++; $display("FAIL mid_rel_enable edge %0d got %b", e, a_enable); end
            n_cmp++; if (a_disable !== (e == 7)) begin n_err++; $display("FAIL mid_rel_disable edge %0d got %b", e, a_disable); end
            n_cmp++; if (a_frame !== (e == 1)) begin n_err++; $display("FAIL mid_rel_frame edge %0d got %b", e, a_frame); end
            n_cmp++; if (a_cpu_clk !== (e >= 3 && e <= 6)) begin n_err++; $display("FAIL mid_rel_cpu_clk edge %0d got %b", e, a_cpu_clk); end
        end
    endtask

    task automatic test_params();
        int   sidx;
        logic exp_clk;
        speed = 2'd1;
        hold  = 1'b0;
        apply_reset();
        for (int k = 0; k < 512; k++) begin
            step();
            sidx    = (e < 2) ? 15 : ((e - 2) / 16) % 16;
            exp_clk = (e % 16 >= 5) && (e % 16 <= 12) && (sidx == 0 || sidx == 8);
            n_cmp++; if (b_setup !== (e % 16 == 2)) begin n_err++; $display("FAIL p_setup edge %0d got %b", e, b_setup); end
            n_cmp++; if (b_enable !== (e % 16 == 5)) begin n_err++; $display("FAIL p_enable edge %0d got %b", e, b_enable); end
            n_cmp++; if (b_disable !== (e % 16 == 13)) begin n_err++; $display("FAIL p_disable edge %0d got %b", e, b_disable); end
            n_cmp++; if (b_frame !== (e % 256 == 2)) begin n_err++; $display("FAIL p_frame edge %0d got %b", e, b_frame); end
            n_cmp++; if (b_idx !== 4'(sidx)) begin n_err++; $display("FAIL p_idx edge %0d got %0d expected %0d", e, b_idx, sidx); end
            n_cmp++; if (b_cpu_clk !== exp_clk) begin n_err++; $display("FAIL p_cpu_clk edge %0d got %b expected %b", e, b_cpu_clk, exp_clk); end
            n_cmp++; if (b_speed !== ((e >= 2) ? 2'd1 : 2'd0)) begin n_err++; $display("FAIL p_speed edge %0d got %0d", e, b_speed); end
        end
    endtask

    initial begin
        rst   = 1'b1;
        speed = 2'd0;
        hold  = 1'b0;
        test_reset();
        test_speed0();
        test_speed3();
        test_speed_switch();
        test_hold();
        test_reset_mid_pulse();
        test_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
